// File: rtl/stopwatch_key_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_key_ctrl_pkg
// Description : Shared state encodings, default debounce settings and the
//               press-pulse bundle for the stopwatch key controller.
// Revision    : 1.0 - initial release
// ============================================================================
package stopwatch_key_ctrl_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;

    // 20 ms of stable level at a 50 MHz system clock
    localparam int DB_CYCLES_DEFAULT = 1000000;
    localparam int DB_W_DEFAULT      = 20;

    typedef struct packed {
        logic start;
        logic clear;
        logic lap;
    } key_press_t;

endpackage : stopwatch_key_ctrl_pkg
`default_nettype wire

// File: rtl/stopwatch_key_ctrl_key_debounce.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce
// Description : Two-flop synchroniser, stable-level debounce counter and
//               one-cycle press pulse for a single active-low push-button.
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce
    import stopwatch_key_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter int DB_W      = DB_W_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    localparam logic [DB_W-1:0] c_LAST = DB_W'(DB_CYCLES - 1);

    logic            r_sync1;
    logic            r_sync2;
    logic [DB_W-1:0] r_cnt;
    logic            r_level;
    logic            r_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_cnt   <= '0;
            r_level <= 1'b1;
            r_last  <= 1'b1;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
            r_last  <= r_level;
            // Any return to the accepted level restarts the stability window
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_LAST) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Only the released-to-pressed edge of the accepted level is reported
    assign press = r_last & ~r_level;

endmodule : key_debounce
`default_nettype wire

// File: rtl/stopwatch_key_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_key_ctrl
// Description : Debounces START/STOP, CLEAR and LAP keys and runs the
//               stopwatch run-control FSM (count enable, clear, lap hold).
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_key_ctrl
    import stopwatch_key_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter int DB_W      = DB_W_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_start_n,
    input  logic       key_clear_n,
    input  logic       key_lap_n,
    output logic       run_en,
    output logic       clr_pulse,
    output logic       lap_hold,
    output logic [1:0] state
);

    key_press_t w_press;

    key_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_start (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_start_n),
        .press (w_press.start)
    );

    key_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_clear (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_clear_n),
        .press (w_press.clear)
    );

    key_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_lap (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_lap_n),
        .press (w_press.lap)
    );

    logic [1:0] r_state;
    logic       r_run_en;
    logic       r_clr_pulse;
    logic       r_lap_hold;

    logic [1:0] w_state_nxt;
    logic       w_clr_nxt;
    logic       w_lap_nxt;

    // Priority inside each state resolves simultaneous presses
    always_comb begin
        w_state_nxt = r_state;
        w_clr_nxt   = 1'b0;
        w_lap_nxt   = r_lap_hold;
        case (r_state)
            ST_IDLE: begin
                if (w_press.clear) begin
                    w_clr_nxt = 1'b1;
                end else if (w_press.start) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_press.start) begin
                    w_state_nxt = ST_PAUSE;
                    w_lap_nxt   = 1'b0;
                end else if (w_press.lap) begin
                    w_lap_nxt = ~r_lap_hold;
                end
            end
            ST_PAUSE: begin
                if (w_press.clear) begin
                    w_state_nxt = ST_IDLE;
                    w_clr_nxt   = 1'b1;
                end else if (w_press.start) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_lap_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_run_en    <= 1'b0;
            r_clr_pulse <= 1'b0;
            r_lap_hold  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_run_en    <= (w_state_nxt == ST_RUN);
            r_clr_pulse <= w_clr_nxt;
            r_lap_hold  <= w_lap_nxt;
        end
    end

    assign state     = r_state;
    assign run_en    = r_run_en;
    assign clr_pulse = r_clr_pulse;
    assign lap_hold  = r_lap_hold;

endmodule : stopwatch_key_ctrl
`default_nettype wire

// File: tb/tb_stopwatch_key_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_stopwatch_key_ctrl
// Description : Directed and randomised key stimulus against a window-based
//               reference model of the stopwatch key controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_key_ctrl;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] keys_n = 3'b111;   // [0] start, [1] clear, [2] lap
    logic       run_en, clr_pulse, lap_hold;
    logic [1:0] state;

    int vectors = 0;
    int miscompares = 0;

    stopwatch_key_ctrl #(.DB_CYCLES(DB), .DB_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .key_start_n (keys_n[0]),
        .key_clear_n (keys_n[1]),
        .key_lap_n   (keys_n[2]),
        .run_en      (run_en),
        .clr_pulse   (clr_pulse),
        .lap_hold    (lap_hold),
        .state       (state)
    );

    always #5 clk = ~clk;

    // Reference model: a key level is accepted once the synchronised pin has
    // disagreed with the accepted level for DB consecutive samples.
    logic [DB:0] m_hist [3];
    logic        m_acc  [3];
    logic        m_pend [3];
    int          m_st;
    logic        m_lap, m_clr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                m_hist[k] = '1;
                m_acc[k]  = 1'b1;
                m_pend[k] = 1'b0;
            end
            m_st = 0; m_lap = 1'b0; m_clr = 1'b0;
        end else begin
            m_clr = 1'b0;
            if (m_st == 0) begin
                if (m_pend[1]) m_clr = 1'b1;
                else if (m_pend[0]) m_st = 1;
            end else if (m_st == 1) begin
                if (m_pend[0]) begin m_st = 2; m_lap = 1'b0; end
                else if (m_pend[2]) m_lap = ~m_lap;
            end else begin
                if (m_pend[1]) begin m_st = 0; m_clr = 1'b1; end
                else if (m_pend[0]) m_st = 1;
            end
            for (int k = 0; k < 3; k++) begin
                m_pend[k] = 1'b0;
                if (m_hist[k][DB:1] == {DB{~m_acc[k]}}) begin
                    m_acc[k]  = ~m_acc[k];
                    m_pend[k] = ~m_acc[k];
                end
                m_hist[k] = {m_hist[k][DB-1:0], keys_n[k]};
            end
        end
    end

    always @(negedge clk) begin
        logic [4:0] exp_v, act_v;
        exp_v = {m_st[1:0], (m_st == 1), m_clr, m_lap};
        act_v = {state, run_en, clr_pulse, lap_hold};
        vectors++;
        if (act_v !== exp_v) begin
            miscompares++;
            $display("FAIL model t=%0t state/run/clr/lap got %b required %b", $time, act_v, exp_v);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_lit(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s got %0d required %0d", name, act, exp);
        end
    endtask

    // Cycles from now until state equals s, bounded
    task automatic wait_state(input logic [1:0] s, output int cnt);
        cnt = 0;
        while (cnt < 40) begin
            @(posedge clk);
            #1;
            cnt++;
            if (state == s) break;
        end
    endtask

    task automatic press(input int k);
        keys_n[k] = 1'b0;
        step(20);
        keys_n[k] = 1'b1;
        step(10);
    endtask

    int lat;

    initial begin
        step(3);
        rst = 1'b0;
        step(50);
        check_lit("idle_state", state, 0);
        check_lit("idle_run_en", run_en, 0);

        keys_n[0] = 1'b0;
        wait_state(2'b01, lat);
        check_lit("start_latency", lat, 7);
        step(13);
        keys_n[0] = 1'b1;
        step(10);
        check_lit("run_en_on", run_en, 1);
        press(0);
        check_lit("second_press_pause", state, 2);
        check_lit("pause_run_en", run_en, 0);
        press(0);
        check_lit("third_press_run", state, 1);
        press(0);

        // Bounce from PAUSE: only the final stable low counts
        keys_n[0] = 1'b0; step(2);
        keys_n[0] = 1'b1; step(1);
        keys_n[0] = 1'b0; step(2);
        keys_n[0] = 1'b1; step(1);
        keys_n[0] = 1'b0;
        wait_state(2'b01, lat);
        check_lit("bounce_latency", lat, 7);
        step(13);
        keys_n[0] = 1'b1;
        step(10);

        press(2);
        check_lit("lap_on", lap_hold, 1);
        press(2);
        check_lit("lap_off", lap_hold, 0);
        press(2);
        press(0);
        check_lit("pause_clears_lap", lap_hold, 0);
        check_lit("pause_after_lap", state, 2);

        press(0);
        press(1);
        check_lit("clear_ignored_in_run", state, 1);
        press(0);
        keys_n[1] = 1'b0;
        wait_state(2'b00, lat);
        check_lit("clear_latency", lat, 7);
        check_lit("clr_pulse_high", clr_pulse, 1);
        step(1);
        check_lit("clr_pulse_one_cycle", clr_pulse, 0);
        step(19);
        keys_n[1] = 1'b1;
        step(10);

        press(0);
        press(0);
        keys_n[1:0] = 2'b00;
        step(20);
        keys_n[1:0] = 2'b11;
        step(10);
        check_lit("simultaneous_clear_wins", state, 0);

        keys_n[0] = 1'b0;
        step(3);
        rst = 1'b1;
        step(3);
        check_lit("reset_state", state, 0);
        rst = 1'b0;
        wait_state(2'b01, lat);
        check_lit("post_reset_latency", lat, 7);
        step(13);
        keys_n[0] = 1'b1;
        step(10);

        begin
            int left [3];
            for (int k = 0; k < 3; k++) left[k] = 0;
            for (int c = 0; c < 3000; c++) begin
                for (int k = 0; k < 3; k++) begin
                    if (left[k] == 0) begin
                        keys_n[k] = ($urandom_range(0, 2) == 0);
                        left[k]   = $urandom_range(1, 14);
                    end
                    left[k]--;
                end
                if ($urandom_range(0, 499) == 0) rst = 1'b1;
                else if (rst && $urandom_range(0, 2) == 0) rst = 1'b0;
                step(1);
            end
            rst = 1'b0;
            keys_n = 3'b111;
            step(20);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_stopwatch_key_ctrl
`default_nettype wire

// File: doc/stopwatch_key_ctrl.md
Name: stopwatch_key_ctrl

Overview:
- Input-side counterpart to the stopwatch display path: turns three raw push-buttons (START/STOP, CLEAR, LAP) into clean control for the 4-digit timer.
- Synchronises and debounces each key, then emits one-cycle press pulses.
- A run-control FSM drives count enable, synchronous clear and display freeze (lap hold).
- Sits between board pins and the pulse generator / digit counters; all outputs are in the clk domain.

Parameters:
- DB_CYCLES, 1000000, consecutive stable samples required to accept a key level (20 ms at 50 MHz); the bench uses 4.
- DB_W, 20, debounce counter width; must satisfy 2^DB_W > DB_CYCLES.

Ports:
- clk  input  1  system clock
- rst  input  1  reset
- key_start_n  input  1  raw START/STOP button, active-low, asynchronous to clk
- key_clear_n  input  1  raw CLEAR button, active-low, asynchronous
- key_lap_n  input  1  raw LAP button, active-low, asynchronous
- run_en  output  1  high while timing; gates the pulse generator
- clr_pulse  output  1  one-cycle synchronous clear to pulse generator and digit counters
- lap_hold  output  1  high = display registers frozen while counting continues
- state  output  2  FSM state: 00 IDLE, 01 RUN, 10 PAUSE

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. On reset: run_en=0, clr_pulse=0, lap_hold=0, state=IDLE. Each key's synchroniser flops, accepted level and last-sample register reset to 1 (released). Debounce counters reset to 0.
- Synchroniser: two flops per key.
- Debounce, per key:
  - While the synced level equals the accepted level, the counter is held at 0.
  - While it differs, the counter increments each cycle.
  - When the counter reaches DB_CYCLES-1 while the level still differs, the accepted level takes the synced level and the counter clears.
  - Any glitch back to the accepted level before that point clears the counter.
- Press pulse: a 1-cycle internal pulse on an accepted 1->0 transition only; release generates nothing.
- Latency from pin edge to press pulse is 2 + DB_CYCLES + 1 cycles. A held key yields exactly one pulse.
- FSM is evaluated on press pulses:
  - IDLE: start -> RUN. Clear -> stays IDLE, clr_pulse=1. Lap ignored.
  - RUN: start -> PAUSE and lap_hold <= 0. Lap toggles lap_hold. Clear ignored.
  - PAUSE: start -> RUN (lap_hold stays 0). Clear -> IDLE with clr_pulse=1. Lap ignored.
- Outputs:
  - run_en = (state==RUN), registered, so it changes the same cycle as state.
  - clr_pulse is registered and high exactly one cycle, the cycle after the clear pulse.
- Simultaneous pulses in the same cycle:
  - IDLE or PAUSE: clear wins and start is dropped.
  - RUN: start wins, clear is ignored, and lap is dropped.
  - Lap alone in RUN toggles lap_hold.
- Reset mid-debounce: counters and accepted levels return to released, so a key held through reset produces a fresh press pulse after the debounce latency once rst drops.
- No press pulses are lost between consecutive cycles; each is handled in its own cycle.

Decomposition:
- Shared defines file holds the state encodings ST_IDLE=2'b00, ST_RUN=2'b01, ST_PAUSE=2'b10 and the default DB_CYCLES.
- One sub-module, key_debounce: synchroniser, debounce counter, accepted level and press-pulse output, parameterised by DB_CYCLES and DB_W. It is instantiated three times; the top level contains the FSM only.

Test Plan (DB_CYCLES=4):
- Reset release, no keys pressed -> state=00, run_en=0, lap_hold=0, clr_pulse=0 for 50 cycles.
- key_start_n low for 20 cycles -> exactly one transition to RUN at cycle 7 after the edge, run_en=1. Second press -> PAUSE, run_en=0. Third press -> RUN.
- key_start_n bouncing (low 2, high 1, low 2, high 1, then low 20) -> only one RUN entry, timed 7 cycles after the start of the final stable low.
- In RUN, press lap twice -> lap_hold goes 1, then 0. Press lap once more, then start -> PAUSE with lap_hold=0.
- Clear in RUN -> ignored, no clr_pulse. Clear in PAUSE -> state IDLE, clr_pulse high exactly 1 cycle.
- In PAUSE, start and clear pressed on the same edge -> IDLE plus clr_pulse, no RUN. Assert rst while key_start_n is held low -> outputs reset; after release, one press pulse 7 cycles later -> RUN.
